sync_updown_counter: RTL and testbench

- Synchronous, fully clocked up/down counter: every flop on the same clock edge, no ripple clocking.
- Counterpart to the team's 4-bit ripple up-counter. Adds down counting, parallel load, count enable and a programmable modulus.
- Provides terminal-count and wrap flags for cascading or for driving timers and dividers elsewhere in the design.

---
 rtl/sync_updown_counter_pkg.sv | 9 +
 rtl/sync_updown_counter_ud_next_state.sv | 46 ++++
 rtl/sync_updown_counter.sv | 65 ++++++
 tb/tb_sync_updown_counter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/sync_updown_counter_pkg.sv
// rtl/sync_updown_counter_pkg.sv - shared types for the synchronous up/down counter
package sync_updown_counter_pkg;

  typedef enum logic {
    DIR_DN = 1'b0,
    DIR_UP = 1'b1
  } dir_e;

endpackage

// File: rtl/sync_updown_counter_ud_next_state.sv
// rtl/sync_updown_counter_ud_next_state.sv - combinational next-count and wrap detect
module sync_updown_counter_ud_next_state
  import sync_updown_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic [WIDTH-1:0] q,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  output logic [WIDTH-1:0] next_q,
  output logic             next_wrap
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

  always_comb begin
    next_q    = q;
    next_wrap = 1'b0;
    if (load) begin
      // Out-of-range load values clamp to the top of the range rather than folding.
      next_q = (d > MAX_CNT) ? MAX_CNT : d;
    end else if (en) begin
      if (q > MAX_CNT) begin
        next_q = '0;
      end else if (dir_e'(up_dn) == DIR_UP) begin
        if (q == MAX_CNT) begin
          next_q    = '0;
          next_wrap = 1'b1;
        end else begin
          next_q = q + 1'b1;
        end
      end else begin
        if (q == '0) begin
          next_q    = MAX_CNT;
          next_wrap = 1'b1;
        end else begin
          next_q = q - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sync_updown_counter.sv
// rtl/sync_updown_counter.sv - modulo-N up/down counter with load, terminal count and wrap pulse
module sync_updown_counter
  import sync_updown_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

  if ((MODULUS < 2) || (MODULUS > (2 ** WIDTH))) begin : g_bad_modulus
    $error("sync_updown_counter: MODULUS out of range for WIDTH");
  end

  logic [WIDTH-1:0] q_q, q_d, next_q;
  logic             wrap_q, wrap_d, next_wrap;

  sync_updown_counter_ud_next_state #(
    .WIDTH  (WIDTH),
    .MODULUS(MODULUS)
  ) u_next (
    .q        (q_q),
    .up_dn    (up_dn),
    .load     (load),
    .d        (d),
    .en       (en),
    .next_q   (next_q),
    .next_wrap(next_wrap)
  );

  always_comb begin
    q_d    = next_q;
    wrap_d = next_wrap;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  // Unregistered so a cascaded stage sees its enable on the same edge.
  always_comb begin
    tc = en & (((dir_e'(up_dn) == DIR_UP) & (q_q == MAX_CNT)) |
               ((dir_e'(up_dn) == DIR_DN) & (q_q == '0)));
  end

  assign q    = q_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_sync_updown_counter.sv
// tb/tb_sync_updown_counter.sv - self-checking bench for sync_updown_counter
module tb_sync_updown_counter;

  localparam int NI = 3;
  localparam int MODS[NI] = '{10, 2, 16};

  logic       clk = 1'b0;
  logic       reset, en, up_dn, load;
  logic [3:0] d;
  logic [3:0] dq[NI];
  logic       dtc[NI];
  logic       dwrap[NI];

  logic       cas_en;
  logic [3:0] q_lo, q_hi;
  logic       tc_lo, tc_hi, wrap_lo, wrap_hi;

  int  checks = 0;
  int  failures = 0;
  bit  chk_on = 1'b0;
  int  m_q[NI];
  bit  m_wrap[NI];

  always #5 clk = ~clk;

  sync_updown_counter #(.WIDTH(4), .MODULUS(10)) u_m10 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .d(d),
    .q(dq[0]), .tc(dtc[0]), .wrap(dwrap[0]));

  sync_updown_counter #(.WIDTH(4), .MODULUS(2)) u_m2 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .d(d),
    .q(dq[1]), .tc(dtc[1]), .wrap(dwrap[1]));

  sync_updown_counter #(.WIDTH(4), .MODULUS(16)) u_m16 (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .d(d),
    .q(dq[2]), .tc(dtc[2]), .wrap(dwrap[2]));

  sync_updown_counter #(.WIDTH(4), .MODULUS(10)) u_lo (
    .clk(clk), .reset(reset), .en(cas_en), .up_dn(1'b1), .load(1'b0), .d(4'd0),
    .q(q_lo), .tc(tc_lo), .wrap(wrap_lo));

  sync_updown_counter #(.WIDTH(4), .MODULUS(10)) u_hi (
    .clk(clk), .reset(reset), .en(tc_lo), .up_dn(1'b1), .load(1'b0), .d(4'd0),
    .q(q_hi), .tc(tc_hi), .wrap(wrap_hi));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: modulo arithmetic on plain integers.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NI; i++) begin
        m_q[i]    = 0;
        m_wrap[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        if (load) begin
          m_q[i]    = (int'(d) < MODS[i]) ? int'(d) : MODS[i] - 1;
          m_wrap[i] = 1'b0;
        end else if (en && up_dn) begin
          m_wrap[i] = (m_q[i] == MODS[i] - 1);
          m_q[i]    = (m_q[i] + 1) % MODS[i];
        end else if (en) begin
          m_wrap[i] = (m_q[i] == 0);
          m_q[i]    = (m_q[i] + MODS[i] - 1) % MODS[i];
        end else begin
          m_wrap[i] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < NI; i++) begin
        check($sformatf("model_q[%0d]", i), 32'(dq[i]), 32'(m_q[i]));
        check($sformatf("model_wrap[%0d]", i), 32'(dwrap[i]), 32'(m_wrap[i]));
        check($sformatf("model_tc[%0d]", i), 32'(dtc[i]),
              32'(en && ((up_dn && m_q[i] == MODS[i] - 1) || (!up_dn && m_q[i] == 0))));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  int lo_w, hi_w;

  initial begin
    reset = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; d = '0; cas_en = 1'b0;
    #3;
    check("reset_q", 32'(dq[0]), 0);
    check("reset_wrap", 32'(dwrap[0]), 0);
    check("reset_tc", 32'(dtc[0]), 0);
    chk_on = 1'b1;
    tick();
    reset = 1'b1;

    en = 1'b1; up_dn = 1'b1;
    repeat (9) tick();
    check("up_q9", 32'(dq[0]), 9);
    #1 check("up_tc_at9", 32'(dtc[0]), 1);
    tick();
    check("up_wrap_q", 32'(dq[0]), 0);
    check("up_wrap_pulse", 32'(dwrap[0]), 1);
    tick();
    check("up_after_wrap_q", 32'(dq[0]), 1);
    check("up_wrap_one_cycle", 32'(dwrap[0]), 0);
    repeat (8) tick();
    check("pre_reset_q9", 32'(dq[0]), 9);
    reset = 1'b0;
    #1;
    check("async_reset_q", 32'(dq[0]), 0);
    check("async_reset_wrap", 32'(dwrap[0]), 0);
    tick();
    en = 1'b0;
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("hold_q", 32'(dq[0]), 0);
      check("hold_tc", 32'(dtc[0]), 0);
    end

    load = 1'b1; d = 4'd2;
    tick();
    check("down_load2", 32'(dq[0]), 2);
    load = 1'b0; en = 1'b1; up_dn = 1'b0;
    tick();
    check("down_q1", 32'(dq[0]), 1);
    tick();
    check("down_q0", 32'(dq[0]), 0);
    #1 check("down_tc_at0", 32'(dtc[0]), 1);
    tick();
    check("down_wrap_q9", 32'(dq[0]), 9);
    check("down_wrap_pulse", 32'(dwrap[0]), 1);
    tick();
    check("down_q8", 32'(dq[0]), 8);
    check("down_wrap_clear", 32'(dwrap[0]), 0);

    load = 1'b1; d = 4'hC; up_dn = 1'b1;
    tick();
    check("clamp_q", 32'(dq[0]), 9);
    check("clamp_wrap", 32'(dwrap[0]), 0);
    check("clamp_m2_q", 32'(dq[1]), 1);
    check("m16_load_c", 32'(dq[2]), 12);
    d = 4'd3;
    tick();
    check("load_over_wrap_q", 32'(dq[0]), 3);
    check("load_over_wrap_wrap", 32'(dwrap[0]), 0);

    d = 4'd5;
    tick();
    load = 1'b0; up_dn = 1'b1;
    tick();
    check("flip_q6", 32'(dq[0]), 6);
    up_dn = 1'b0;
    tick();
    check("flip_q5", 32'(dq[0]), 5);
    up_dn = 1'b1;
    tick();
    check("flip_q6b", 32'(dq[0]), 6);

    load = 1'b1; d = 4'd1;
    tick();
    load = 1'b0;
    for (int k = 0; k < 4; k++) begin
      up_dn = (k % 2 == 0);
      tick();
      check("m2_back_to_back_wrap", 32'(dwrap[1]), 1);
    end

    for (int k = 0; k < 3000; k++) begin
      load  = ($urandom_range(7) == 0);
      en    = ($urandom_range(3) != 0);
      up_dn = $urandom_range(1) == 1;
      d     = 4'($urandom_range(15));
      if ($urandom_range(199) == 0) begin
        reset = 1'b0;
        #1 reset = 1'b1;
      end
      tick();
    end

    en = 1'b0; load = 1'b0;
    reset = 1'b0;
    #1 reset = 1'b1;
    lo_w = 0; hi_w = 0;
    cas_en = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      @(negedge clk);
      lo_w += int'(wrap_lo);
      hi_w += int'(wrap_hi);
    end
    cas_en = 1'b0;
    check("cascade_lo_q", 32'(q_lo), 0);
    check("cascade_hi_q", 32'(q_hi), 0);
    check("cascade_lo_wraps", 32'(lo_w), 10);
    check("cascade_hi_wraps", 32'(hi_w), 1);

    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
